// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that shares one W-bit register between two 4-phase req/ack ports.
// Each port can read or write the register. Accesses are serialised, and read data is returned on rdata.
module reg_share_arbiter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         wr0,
    input  logic [W-1:0] wdata0,
    output logic         ack0,
    input  logic         req1,
    input  logic         wr1,
    input  logic [W-1:0] wdata1,
    output logic         ack1,
    output logic [W-1:0] rdata,
    output logic [W-1:0] reg_q,
    output logic         busy,
    output logic         owner
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_owner;
    logic [W-1:0]   r_reg;
    logic [W-1:0]   r_rdata;

    logic           w_req_own;
    logic           w_wr_own;
    logic [W-1:0]   w_wdata_own;

    assign w_req_own   = r_owner ? req1   : req0;
    assign w_wr_own    = r_owner ? wr1    : wr0;
    assign w_wdata_own = r_owner ? wdata1 : wdata0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (req0 || req1) w_next = ST_ACCESS;
            ST_ACCESS:  w_next = ST_RELEASE;
            ST_RELEASE: if (!w_req_own) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // The grant is taken in IDLE. Under contention the port that was not served last wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= 1'b1;
            r_reg   <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == ST_IDLE && (req0 || req1)) begin
                r_owner <= (req0 && req1) ? ~r_owner : req1;
            end
            if (r_state == ST_ACCESS) begin
                if (w_wr_own) begin
                    r_reg <= w_wdata_own;
                end else begin
                    r_rdata <= r_reg;
                end
            end
        end
    end

    // NOTE: every output gets a default first, so this block cannot infer a latch.
    always_comb begin
        ack0 = 1'b0;
        ack1 = 1'b0;
        busy = (r_state != ST_IDLE);
        if (r_state == ST_RELEASE) begin
            ack0 = ~r_owner;
            ack1 = r_owner;
        end
    end

    assign rdata = r_rdata;
    assign reg_q = r_reg;
    assign owner = r_owner;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter.
// It runs a table of directed vectors, then randomised traffic checked against a transaction-level model.
module tb_reg_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, wr0, req1, wr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, busy, owner;
    logic [15:0] rdata, reg_q;

    int errors = 0;
    int checks = 0;

    reg_share_arbiter #(.W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .wr0    (wr0),
        .wdata0 (wdata0),
        .ack0   (ack0),
        .req1   (req1),
        .wr1    (wr1),
        .wdata1 (wdata1),
        .ack1   (ack1),
        .rdata  (rdata),
        .reg_q  (reg_q),
        .busy   (busy),
        .owner  (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, req0, wr0;
        logic [15:0] d0;
        logic        req1, wr1;
        logic [15:0] d1;
        logic        a0, a1, bz, ow;
        logic [15:0] rd, rq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic q0, input logic w0, input logic [15:0] d0,
                     input logic q1, input logic w1, input logic [15:0] d1,
                     input logic a0, input logic a1, input logic bz, input logic ow,
                     input logic [15:0] rd, input logic [15:0] rq);
        vec_t t;
        t.rst_n = r; t.req0 = q0; t.wr0 = w0; t.d0 = d0;
        t.req1 = q1; t.wr1 = w1; t.d1 = d1;
        t.a0 = a0; t.a1 = a1; t.bz = bz; t.ow = ow; t.rd = rd; t.rq = rq;
        vecs.push_back(t);
    endtask

    // The model tracks the transaction in service: the port being served and whether its access is done.
    int          m_port;
    bit          m_done;
    bit          m_owner;
    logic [15:0] m_reg, m_rdata;

    task automatic model_step(input logic r, input logic q0, input logic w0, input logic [15:0] d0,
                              input logic q1, input logic w1, input logic [15:0] d1);
        if (!r) begin
            m_port = -1; m_done = 0; m_owner = 1; m_reg = 0; m_rdata = 0;
        end else if (m_port < 0) begin
            if (q0 && q1)  m_owner = !m_owner;
            else if (q0)   m_owner = 0;
            else if (q1)   m_owner = 1;
            if (q0 || q1) begin
                m_port = int'(m_owner);
                m_done = 0;
            end
        end else if (!m_done) begin
            if ((m_port == 1) ? w1 : w0) m_reg = (m_port == 1) ? d1 : d0;
            else                         m_rdata = m_reg;
            m_done = 1;
        end else if (!((m_port == 1) ? q1 : q0)) begin
            m_port = -1;
            m_done = 0;
        end
    endtask

    function automatic logic [35:0] model_out();
        logic e0, e1;
        e0 = (m_port == 0) && m_done;
        e1 = (m_port == 1) && m_done;
        return {e0, e1, (m_port >= 0), m_owner, m_rdata, m_reg};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; req0 = 0; wr0 = 0; wdata0 = 0; req1 = 0; wr1 = 0; wdata1 = 0;

        // Reset.
        v(0,0,0,16'h0,0,0,16'h0,         0,0,0,1,16'h0,16'h0);
        v(0,0,0,16'h0,0,0,16'h0,         0,0,0,1,16'h0,16'h0);
        // Single write by port 0.
        v(1,1,1,16'hA5A5,0,0,16'h0,      0,0,1,0,16'h0,16'h0);
        v(1,1,1,16'hA5A5,0,0,16'h0,      1,0,1,0,16'h0,16'hA5A5);
        v(1,1,1,16'hA5A5,0,0,16'h0,      1,0,1,0,16'h0,16'hA5A5);
        v(1,0,0,16'h0,0,0,16'h0,         0,0,0,0,16'h0,16'hA5A5);
        // Port 0 writes 1234, then port 1 reads it back.
        v(1,1,1,16'h1234,0,0,16'h0,      0,0,1,0,16'h0,16'hA5A5);
        v(1,1,1,16'h1234,0,0,16'h0,      1,0,1,0,16'h0,16'h1234);
        v(1,0,0,16'h0,0,0,16'h0,         0,0,0,0,16'h0,16'h1234);
        v(1,0,0,16'h0,1,0,16'h0,         0,0,1,1,16'h0,16'h1234);
        v(1,0,0,16'h0,1,0,16'h0,         0,1,1,1,16'h1234,16'h1234);
        v(1,0,0,16'h0,0,0,16'h0,         0,0,0,1,16'h1234,16'h1234);
        // Contention from reset: port 0 is served first, then port 1.
        v(0,0,0,16'h0,0,0,16'h0,         0,0,0,1,16'h0,16'h0);
        v(1,1,1,16'h0001,1,1,16'h0002,   0,0,1,0,16'h0,16'h0);
        v(1,1,1,16'h0001,1,1,16'h0002,   1,0,1,0,16'h0,16'h0001);
        v(1,0,0,16'h0,1,1,16'h0002,      0,0,0,0,16'h0,16'h0001);
        v(1,0,0,16'h0,1,1,16'h0002,      0,0,1,1,16'h0,16'h0001);
        v(1,0,0,16'h0,1,1,16'h0002,      0,1,1,1,16'h0,16'h0002);
        v(1,0,0,16'h0,0,0,16'h0,         0,0,0,1,16'h0,16'h0002);
        // Repeated contention: the last owner was 1, so port 0 goes first again.
        v(1,1,1,16'h0003,1,1,16'h0004,   0,0,1,0,16'h0,16'h0002);
        v(1,1,1,16'h0003,1,1,16'h0004,   1,0,1,0,16'h0,16'h0003);
        v(1,0,0,16'h0,1,1,16'h0004,      0,0,0,0,16'h0,16'h0003);
        v(1,0,0,16'h0,1,1,16'h0004,      0,0,1,1,16'h0,16'h0003);
        v(1,0,0,16'h0,1,1,16'h0004,      0,1,1,1,16'h0,16'h0004);
        v(1,0,0,16'h0,0,0,16'h0,         0,0,0,1,16'h0,16'h0004);
        // Port 0 holds its read while port 1 waits.
        v(1,1,0,16'h0,0,0,16'h0,         0,0,1,0,16'h0,16'h0004);
        v(1,1,0,16'h0,1,1,16'hBEEF,      1,0,1,0,16'h0004,16'h0004);
        v(1,1,0,16'h0,1,1,16'hBEEF,      1,0,1,0,16'h0004,16'h0004);
        v(1,0,0,16'h0,1,1,16'hBEEF,      0,0,0,0,16'h0004,16'h0004);
        v(1,0,0,16'h0,1,1,16'hBEEF,      0,0,1,1,16'h0004,16'h0004);
        v(1,0,0,16'h0,1,1,16'hBEEF,      0,1,1,1,16'h0004,16'hBEEF);
        v(1,0,0,16'h0,0,0,16'h0,         0,0,0,1,16'h0004,16'hBEEF);
        // Reset during the ACCESS state of a write: the write must not happen.
        v(1,1,1,16'hFFFF,0,0,16'h0,      0,0,1,0,16'h0004,16'hBEEF);
        v(0,1,1,16'hFFFF,0,0,16'h0,      0,0,0,1,16'h0,16'h0);
        v(1,0,0,16'h0,0,0,16'h0,         0,0,0,1,16'h0,16'h0);
        // Port 1 drops req before ack: the write still completes and ack pulses for one cycle.
        v(1,0,0,16'h0,1,1,16'h5555,      0,0,1,1,16'h0,16'h0);
        v(1,0,0,16'h0,0,1,16'h5555,      0,1,1,1,16'h0,16'h5555);
        v(1,0,0,16'h0,0,0,16'h0,         0,0,0,1,16'h0,16'h5555);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; req0 = vecs[i].req0; wr0 = vecs[i].wr0; wdata0 = vecs[i].d0;
            req1 = vecs[i].req1; wr1 = vecs[i].wr1; wdata1 = vecs[i].d1;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  64'({ack0, ack1, busy, owner, rdata, reg_q}),
                  64'({vecs[i].a0, vecs[i].a1, vecs[i].bz, vecs[i].ow, vecs[i].rd, vecs[i].rq}));
            if (ack0 && ack1) check($sformatf("vec%0d_excl", i), 64'(ack0 & ack1), 64'd0);
        end

        // Random traffic against the model. Start from a known reset.
        rst_n = 0; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; wdata0 = 0; wdata1 = 0;
        @(posedge clk); #1;
        model_step(rst_n, req0, wr0, wdata0, req1, wr1, wdata1);
        check("rand_reset", 64'({ack0, ack1, busy, owner, rdata, reg_q}), 64'(model_out()));

        for (int c = 0; c < 3000; c++) begin
            logic [35:0] cur;
            cur = model_out();
            rst_n = ($urandom_range(0, 199) != 0);
            if (!req0) begin
                if ($urandom_range(0, 2) == 0) begin
                    req0 = 1; wr0 = 1'($urandom_range(0, 1)); wdata0 = 16'($urandom);
                end
            end else if ((cur[35] && $urandom_range(0, 1) == 0) || $urandom_range(0, 49) == 0) begin
                req0 = 0;
            end
            if (!req1) begin
                if ($urandom_range(0, 2) == 0) begin
                    req1 = 1; wr1 = 1'($urandom_range(0, 1)); wdata1 = 16'($urandom);
                end
            end else if ((cur[34] && $urandom_range(0, 1) == 0) || $urandom_range(0, 49) == 0) begin
                req1 = 0;
            end
            @(posedge clk); #1;
            model_step(rst_n, req0, wr0, wdata0, req1, wr1, wdata1);
            check($sformatf("rand%0d", c),
                  64'({ack0, ack1, busy, owner, rdata, reg_q}), 64'(model_out()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
